vigenere_stream: RTL and testbench
==================================

VIGENERE_STREAM -- requirements
Module: vigenere_stream

Interface
REQ-001 SHALL have parameter N, default 8, meaning character data width (>= 8; only bits [7:0] are interpreted as ASCII, upper bits pass through).
REQ-002 SHALL have parameter KEY_DEPTH, default 16, meaning the number of key-shift entries (power of 2, >= 2).
REQ-003 SHALL have one clock and an asynchronous, active-low reset: port clock (rising edge) and port rst (asynchronous, active-low).
REQ-004 SHALL list ports as name, direction, width, meaning:
- clock  in  1  clock
- rst  in  1  async active-low reset
- key_wr  in  1  key write strobe
- key_addr  in  $clog2(KEY_DEPTH)  key entry index
- key_data  in  5  shift value, 0-31
- key_len  in  $clog2(KEY_DEPTH)+1  active key length, 0..KEY_DEPTH
- mode  in  2  00 encrypt, 01 decrypt, 10/11 bypass
- restart  in  1  pulse: rewind key index, return to IDLE
- in_valid  in  1  input handshake
- in_ready  out  1  input handshake
- din  in  N  input character
- out_valid  out  1  output handshake
- out_ready  in  1  output handshake
- dout  out  N  output character
- busy  out  1  FSM in RUN
- key_err  out  1  sticky error flag

Function
REQ-005 SHALL run an FSM with states IDLE and RUN.
- IDLE->RUN on the first accepted input beat (in_valid && in_ready).
- RUN->IDLE on restart.
- busy=1 in RUN.
REQ-006 SHALL latch mode and key_len on the IDLE->RUN transition; changes while in RUN have no effect.
REQ-007 SHALL accept key_wr only in IDLE:
- Stored value = key_data mod 26.
- key_err set if key_data >= 26.
- key_err set if key_wr arrives in RUN; that write is discarded.
REQ-008 SHALL use a single output register with latency 1: in_ready = !out_valid || out_ready.
REQ-009 SHALL hold dout and out_valid stable while out_valid && !out_ready.
REQ-010 SHALL rotate letters with shift k = key[idx]:
- 'A'-'Z' (0x41-0x5A): (c-'A'±k) mod 26 + 'A'
- 'a'-'z' (0x61-0x7A): (c-'a'±k) mod 26 + 'a'
- + for encrypt, - for decrypt; case is preserved.
REQ-011 SHALL pass non-letters unchanged, and they SHALL NOT advance idx.
REQ-012 SHALL advance idx by 1 on each accepted letter, wrapping from key_len-1 to 0.
REQ-013 SHALL treat key_len=0 as shift 0, with idx held at 0.
REQ-014 SHALL treat key_len > KEY_DEPTH as KEY_DEPTH.
REQ-015 SHALL, in bypass mode, pass all characters unchanged; idx still advances on letters.
REQ-016 SHALL, when restart coincides with an accepted beat, process that beat with idx 0; the next letter uses idx 1, or idx 0 if the latched key_len <= 1.
REQ-017 SHALL NOT cancel a pending output beat on restart.

Reset
REQ-018 SHALL, on rst low, asynchronously clear all of the following: state=IDLE, idx=0, out_valid=0, dout=0, key_err=0, latched mode=00, latched key_len=0.
REQ-019 SHALL hold in_ready=1 while out_valid=0 after reset.
REQ-020 SHALL clear all key entries to 0 on reset.
REQ-021 SHALL discard any in-flight beat when reset is asserted mid-stream.

Configuration
REQ-022 SHALL support macro VIGENERE_DIGIT_EN:
- When defined: '0'-'9' (0x30-0x39) rotate as (c-'0'±(k mod 10)) mod 10 + '0', and digits advance idx.
- When undefined: digits are non-letters per REQ-011.

Structure
REQ-023 SHALL place the mode enum (ENC, DEC, BYP), ALPHA_LEN=26, DIGIT_LEN=10 and the ASCII range constants in a shared package cipher_pkg.
REQ-024 SHALL implement per-character rotation in the combinational sub-module char_rotate (inputs: char, shift, mode; outputs: rotated char, is_alpha).

Verification
REQ-025 SHALL cover: key[0]=3, key_len=1, encrypt, din 0x41 'A' -> dout 0x44 'D' one cycle after accept.
REQ-026 SHALL cover: key={1,2,3}, key_len=3, encrypt, "AAAA" -> "BCDB"; decrypt of "BCDB" -> "AAAA".
REQ-027 SHALL cover: key={1,2}, encrypt, "z z" (0x7A,0x20,0x7A) -> "a" 0x20 "b"; the space does not advance idx.
REQ-028 SHALL cover: out_ready=0 for 5 cycles with out_valid=1 -> dout stable, in_ready=0, no beats lost or duplicated.
REQ-029 SHALL cover: key_wr with key_data=26 in IDLE -> entry stores 0, key_err=1; key_wr in RUN -> ignored, key_err=1.
REQ-030 SHALL cover: rst low mid-stream -> out_valid=0, busy=0, key entries 0; next "A" with key_len=1 -> "A".

Source files
------------

// File: rtl/cipher_pkg.sv
// Shared types and constants for the Vigenere stream cipher.
// Holds the cipher mode enum, controller state enum, alphabet sizes,
// ASCII range bounds and the modular offset helper used by char_rotate.
package cipher_pkg;

  typedef enum logic [1:0] {
    ENC = 2'b00,
    DEC = 2'b01,
    BYP = 2'b10
  } mode_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int ALPHA_LEN = 26;
  localparam int DIGIT_LEN = 10;

  localparam logic [7:0] UPPER_A = 8'h41;
  localparam logic [7:0] UPPER_Z = 8'h5A;
  localparam logic [7:0] LOWER_A = 8'h61;
  localparam logic [7:0] LOWER_Z = 8'h7A;
  localparam logic [7:0] DIGIT_0 = 8'h30;
  localparam logic [7:0] DIGIT_9 = 8'h39;

  // Both 2'b10 and 2'b11 select bypass.
  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'b00:   return ENC;
      2'b01:   return DEC;
      default: return BYP;
    endcase
  endfunction

  // (off +/- k) mod len, for off < len and k < len.
  // Decrypt adds len before subtracting so the sum never goes negative.
  function automatic logic [7:0] rotate_offset(input logic [7:0] off,
                                               input logic [7:0] k,
                                               input logic [7:0] len,
                                               input logic       dec);
    logic [7:0] t;
    t = dec ? (off + len - k) : (off + k);
    if (t >= len) t = t - len;
    return t;
  endfunction

endpackage

// File: rtl/char_rotate.sv
// Combinational single-character rotation.
// Letters rotate within their own case; everything else passes through.
// Optional macro VIGENERE_DIGIT_EN: digits rotate by (shift mod 10) and
// report is_alpha so they also advance the key index.
module char_rotate
  import cipher_pkg::*;
(
  input  logic [7:0] ch,
  input  logic [4:0] shift,
  input  mode_t      mode,
  output logic [7:0] rot_ch,
  output logic       is_alpha
);

  logic       dec;
  logic       active;
`ifdef VIGENERE_DIGIT_EN
  logic [4:0] shift_digit;
`endif

  assign dec    = (mode == DEC);
  assign active = (mode != BYP);
`ifdef VIGENERE_DIGIT_EN
  assign shift_digit = shift % 5'(DIGIT_LEN);
`endif

  // Classify the character and apply the rotation for its class.
  // NOTE: defaults assigned first so every path drives both outputs and
  // no latch is inferred.
  always_comb begin
    rot_ch   = ch;
    is_alpha = 1'b0;
    if (ch >= UPPER_A && ch <= UPPER_Z) begin
      is_alpha = 1'b1;
      if (active)
        rot_ch = UPPER_A + rotate_offset(ch - UPPER_A, {3'b000, shift},
                                         8'(ALPHA_LEN), dec);
    end else if (ch >= LOWER_A && ch <= LOWER_Z) begin
      is_alpha = 1'b1;
      if (active)
        rot_ch = LOWER_A + rotate_offset(ch - LOWER_A, {3'b000, shift},
                                         8'(ALPHA_LEN), dec);
    end
`ifdef VIGENERE_DIGIT_EN
    else if (ch >= DIGIT_0 && ch <= DIGIT_9) begin
      is_alpha = 1'b1;
      if (active)
        rot_ch = DIGIT_0 + rotate_offset(ch - DIGIT_0, {3'b000, shift_digit},
                                         8'(DIGIT_LEN), dec);
    end
`endif
  end

endmodule

// File: rtl/vigenere_stream.sv
// Streaming Vigenere cipher with a valid/ready input, a single registered
// output stage and a writable key table.
// Mode and key length are taken live for the first beat of a run and held
// for the remainder of it; restart rewinds the key index and returns to IDLE.
// Optional macro VIGENERE_DIGIT_EN (see char_rotate) also rotates digits.
module vigenere_stream
  import cipher_pkg::*;
#(
  parameter int N         = 8,
  parameter int KEY_DEPTH = 16
) (
  input  logic                         clock,
  input  logic                         rst,
  input  logic                         key_wr,
  input  logic [$clog2(KEY_DEPTH)-1:0] key_addr,
  input  logic [4:0]                   key_data,
  input  logic [$clog2(KEY_DEPTH):0]   key_len,
  input  logic [1:0]                   mode,
  input  logic                         restart,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [N-1:0]                 din,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [N-1:0]                 dout,
  output logic                         busy,
  output logic                         key_err
);

  localparam int AW = $clog2(KEY_DEPTH);
  localparam int LW = AW + 1;

  state_t         state_q, state_d;
  mode_t          mode_q;
  logic [LW-1:0]  len_q;
  logic [AW-1:0]  idx_q;
  logic [4:0]     key_mem [KEY_DEPTH];

  logic           accept;
  mode_t          eff_mode;
  logic [LW-1:0]  live_len;
  logic [LW-1:0]  eff_len;
  logic [AW-1:0]  cur_idx;
  logic [LW-1:0]  idx_inc;
  logic [AW-1:0]  next_idx;
  logic [4:0]     shift;
  logic [7:0]     rot_ch;
  logic           is_alpha;
  logic [N-1:0]   dout_d;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Lengths beyond the table size use the whole table.
  assign live_len = (key_len > LW'(KEY_DEPTH)) ? LW'(KEY_DEPTH) : key_len;
  assign eff_mode = (state_q == IDLE) ? decode_mode(mode) : mode_q;
  assign eff_len  = (state_q == IDLE) ? live_len : len_q;

  // A beat coinciding with restart is ciphered from the top of the key.
  assign cur_idx  = restart ? '0 : idx_q;
  assign shift    = (eff_len == '0) ? 5'd0 : key_mem[cur_idx];
  assign idx_inc  = {1'b0, cur_idx} + LW'(1);

  char_rotate u_rotate (
    .ch       (din[7:0]),
    .shift    (shift),
    .mode     (eff_mode),
    .rot_ch   (rot_ch),
    .is_alpha (is_alpha)
  );

  // Key index after the current letter: wraps at the active length, pinned at 0 when empty.
  always_comb begin
    next_idx = '0;
    if (eff_len != '0 && idx_inc < eff_len)
      next_idx = idx_inc[AW-1:0];
  end

  // Output character: upper bits pass through, low byte is the rotated ASCII.
  // NOTE: blocking assignments in combinational logic; the later partial
  // assignment overrides the default for bits [7:0].
  always_comb begin
    dout_d      = din;
    dout_d[7:0] = rot_ch;
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so all registers
  // update from the same pre-edge values.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic: first accepted beat starts a run, restart ends it.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept && !restart) state_d = RUN;
      RUN:     if (restart)            state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-derived outputs.
  always_comb begin
    busy = (state_q == RUN);
  end

  // Capture mode and key length for the run on the first accepted beat.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      mode_q <= ENC;
      len_q  <= '0;
    end else if (state_q == IDLE && accept) begin
      mode_q <= eff_mode;
      len_q  <= live_len;
    end
  end

  // Key index: advance on accepted letters, rewind on restart.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst)                    idx_q <= '0;
    else if (accept && is_alpha) idx_q <= next_idx;
    else if (restart)            idx_q <= '0;
  end

  // Key table writes (IDLE only, reduced mod 26) and the sticky error flag.
  // NOTE: the key table is cleared on reset, so it is built from flops
  // rather than a RAM macro.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < KEY_DEPTH; i++) key_mem[i] <= '0;
      key_err <= 1'b0;
    end else if (key_wr) begin
      if (state_q == RUN) begin
        key_err <= 1'b1;
      end else if (key_data >= 5'(ALPHA_LEN)) begin
        key_mem[key_addr] <= key_data - 5'(ALPHA_LEN);
        key_err           <= 1'b1;
      end else begin
        key_mem[key_addr] <= key_data;
      end
    end
  end

  // Single output register: load on accept, drain on out_ready, hold otherwise.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      dout      <= dout_d;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vigenere_stream.sv
// Directed self-checking bench for vigenere_stream (N=8, KEY_DEPTH=16).
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vigenere_stream;

  logic       clock = 1'b0;
  logic       rst;
  logic       key_wr;
  logic [3:0] key_addr;
  logic [4:0] key_data;
  logic [4:0] key_len;
  logic [1:0] mode;
  logic       restart;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] din;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] dout;
  logic       busy;
  logic       key_err;

  int checks = 0;
  int errors = 0;

  vigenere_stream #(.N(8), .KEY_DEPTH(16)) dut (
    .clock     (clock),
    .rst       (rst),
    .key_wr    (key_wr),
    .key_addr  (key_addr),
    .key_data  (key_data),
    .key_len   (key_len),
    .mode      (mode),
    .restart   (restart),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din       (din),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .dout      (dout),
    .busy      (busy),
    .key_err   (key_err)
  );

  always #5 clock = ~clock;

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  // ---------------- stimulus helpers (start and end on a falling edge) ----

  task automatic write_key(input logic [3:0] a, input logic [4:0] d);
    key_wr = 1'b1; key_addr = a; key_data = d;
    @(posedge clock); @(negedge clock);
    key_wr = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clock); @(negedge clock);
    restart = 1'b0;
  endtask

  // Send one character with out_ready=1 and return the output sampled one
  // cycle after acceptance.
  task automatic send(input logic [7:0] c, output logic [7:0] got, output logic gv);
    int n;
    n = 0;
    in_valid = 1'b1; din = c;
    while (!in_ready && n < 20) begin
      @(negedge clock); n++;
    end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_ready: in_ready=%0b required 1 within 20 cycles", in_ready);
    end
    @(posedge clock); @(negedge clock);
    in_valid = 1'b0;
    got = dout; gv = out_valid;
    @(posedge clock); @(negedge clock);
  endtask

  // ---------------- tests ----------------

  task automatic test_reset();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b exp 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL reset_busy: got %0b exp 0", busy); end
    checks++; if (in_ready !== 1'b1)  begin errors++; $display("FAIL reset_in_ready: got %0b exp 1", in_ready); end
    checks++; if (key_err !== 1'b0)   begin errors++; $display("FAIL reset_key_err: got %0b exp 0", key_err); end
    checks++; if (dout !== 8'h00)     begin errors++; $display("FAIL reset_dout: got %h exp 00", dout); end
  endtask

  task automatic test_single();
    logic [7:0] g; logic v;
    write_key(4'd0, 5'd3);
    key_len = 5'd1; mode = 2'b00;
    send(8'h41, g, v);
    checks++; if (v !== 1'b1)   begin errors++; $display("FAIL single_valid: got %0b exp 1", v); end
    checks++; if (g !== 8'h44)  begin errors++; $display("FAIL single_dout: got %h exp 44", g); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0b exp 1", busy); end
    pulse_restart();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL restart_busy: got %0b exp 0", busy); end
  endtask

  task automatic test_multi();
    string pt = "AAAA";
    string ct = "BCDB";
    logic [7:0] g; logic v;
    write_key(4'd0, 5'd1); write_key(4'd1, 5'd2); write_key(4'd2, 5'd3);
    key_len = 5'd3; mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      send(pt[i], g, v);
      checks++; if (g !== ct[i]) begin errors++; $display("FAIL enc_multi[%0d]: got %h exp %h", i, g, ct[i]); end
    end
    pulse_restart();
    mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      send(ct[i], g, v);
      checks++; if (g !== pt[i]) begin errors++; $display("FAIL dec_multi[%0d]: got %h exp %h", i, g, pt[i]); end
    end
    pulse_restart();
    mode = 2'b00;
  endtask

  task automatic test_nonletter();
    logic [7:0] src [4];
    logic [7:0] exp [4];
    logic [7:0] g; logic v;
    src = '{8'h7A, 8'h20, 8'h7A, 8'h35};
`ifdef VIGENERE_DIGIT_EN
    exp = '{8'h61, 8'h20, 8'h62, 8'h36};
`else
    exp = '{8'h61, 8'h20, 8'h62, 8'h35};
`endif
    write_key(4'd0, 5'd1); write_key(4'd1, 5'd2);
    key_len = 5'd2; mode = 2'b00;
    for (int i = 0; i < 4; i++) begin
      send(src[i], g, v);
      checks++; if (g !== exp[i]) begin errors++; $display("FAIL nonletter[%0d]: got %h exp %h", i, g, exp[i]); end
    end
    pulse_restart();
  endtask

  task automatic test_latch();
    logic [7:0] g; logic v;
    // keys: 0->1, 1->2, 2->3
    key_len = 5'd2; mode = 2'b00;
    send(8'h41, g, v);
    checks++; if (g !== 8'h42) begin errors++; $display("FAIL latch_first: got %h exp 42", g); end
    mode = 2'b10; key_len = 5'd3;
    send(8'h41, g, v);
    checks++; if (g !== 8'h43) begin errors++; $display("FAIL latch_mode: got %h exp 43", g); end
    send(8'h41, g, v);
    checks++; if (g !== 8'h42) begin errors++; $display("FAIL latch_len: got %h exp 42", g); end
    pulse_restart();
    send(8'h61, g, v);
    checks++; if (g !== 8'h61) begin errors++; $display("FAIL bypass_10: got %h exp 61", g); end
    pulse_restart();
    mode = 2'b11;
    send(8'h51, g, v);
    checks++; if (g !== 8'h51) begin errors++; $display("FAIL bypass_11: got %h exp 51", g); end
    pulse_restart();
    mode = 2'b00; key_len = 5'd0;
    send(8'h41, g, v);
    checks++; if (g !== 8'h41) begin errors++; $display("FAIL len0_a: got %h exp 41", g); end
    send(8'h62, g, v);
    checks++; if (g !== 8'h62) begin errors++; $display("FAIL len0_b: got %h exp 62", g); end
    pulse_restart();
  endtask

  task automatic test_backpressure();
    // keys 0->1, 1->2; first 'A' -> 'B', second 'A' -> 'C'
    key_len = 5'd2; mode = 2'b00;
    out_ready = 1'b0; in_valid = 1'b1; din = 8'h41;
    @(posedge clock); @(negedge clock);
    checks++; if (out_valid !== 1'b1 || dout !== 8'h42) begin errors++; $display("FAIL bp_first: valid=%0b dout=%h exp 1/42", out_valid, dout); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      checks++;
      if (out_valid !== 1'b1 || dout !== 8'h42 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold[%0d]: valid=%0b dout=%h ready=%0b exp 1/42/0", i, out_valid, dout, in_ready);
      end
    end
    out_ready = 1'b1;
    @(posedge clock); @(negedge clock);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || dout !== 8'h43) begin errors++; $display("FAIL bp_second: valid=%0b dout=%h exp 1/43", out_valid, dout); end
    @(posedge clock); @(negedge clock);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_drain: valid=%0b exp 0", out_valid); end
    pulse_restart();
  endtask

  task automatic test_restart_coincide();
    logic [7:0] g; logic v;
    // keys 0->1, 1->2, 2->3
    key_len = 5'd3; mode = 2'b00;
    send(8'h41, g, v);
    send(8'h41, g, v);
    checks++; if (g !== 8'h43) begin errors++; $display("FAIL rc_pre: got %h exp 43", g); end
    in_valid = 1'b1; din = 8'h41; restart = 1'b1;
    @(posedge clock); @(negedge clock);
    in_valid = 1'b0; restart = 1'b0;
    checks++; if (dout !== 8'h42 || out_valid !== 1'b1) begin errors++; $display("FAIL rc_beat: dout=%h valid=%0b exp 42/1", dout, out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rc_busy: got %0b exp 0", busy); end
    @(posedge clock); @(negedge clock);
    send(8'h41, g, v);
    checks++; if (g !== 8'h43) begin errors++; $display("FAIL rc_next: got %h exp 43", g); end
    pulse_restart();
    // key_len 1: letter after the coinciding beat stays on idx 0
    key_len = 5'd1;
    send(8'h41, g, v);
    in_valid = 1'b1; din = 8'h41; restart = 1'b1;
    @(posedge clock); @(negedge clock);
    in_valid = 1'b0; restart = 1'b0;
    @(posedge clock); @(negedge clock);
    send(8'h41, g, v);
    checks++; if (g !== 8'h42) begin errors++; $display("FAIL rc_len1: got %h exp 42", g); end
    pulse_restart();
  endtask

  task automatic test_key_err();
    logic [7:0] g; logic v;
    checks++; if (key_err !== 1'b0) begin errors++; $display("FAIL kerr_pre: got %0b exp 0", key_err); end
    write_key(4'd0, 5'd26);
    checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL kerr_set: got %0b exp 1", key_err); end
    key_len = 5'd1; mode = 2'b00;
    send(8'h41, g, v);
    checks++; if (g !== 8'h41) begin errors++; $display("FAIL kerr_mod26: got %h exp 41", g); end
    write_key(4'd0, 5'd5);
    checks++; if (key_err !== 1'b1) begin errors++; $display("FAIL kerr_run: got %0b exp 1", key_err); end
    send(8'h41, g, v);
    checks++; if (g !== 8'h41) begin errors++; $display("FAIL kerr_discard: got %h exp 41", g); end
    pulse_restart();
    write_key(4'd1, 5'd27);
    key_len = 5'd2;
    send(8'h41, g, v);
    send(8'h41, g, v);
    checks++; if (g !== 8'h42) begin errors++; $display("FAIL kerr_27: got %h exp 42", g); end
    pulse_restart();
  endtask

  task automatic test_mid_reset();
    logic [7:0] g; logic v;
    write_key(4'd0, 5'd4);
    key_len = 5'd1; mode = 2'b00;
    out_ready = 1'b0; in_valid = 1'b1; din = 8'h41;
    @(posedge clock); @(negedge clock);
    checks++; if (out_valid !== 1'b1 || dout !== 8'h45) begin errors++; $display("FAIL mr_pending: valid=%0b dout=%h exp 1/45", out_valid, dout); end
    rst = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mr_valid: got %0b exp 0", out_valid); end
    checks++; if (busy !== 1'b0)      begin errors++; $display("FAIL mr_busy: got %0b exp 0", busy); end
    checks++; if (key_err !== 1'b0)   begin errors++; $display("FAIL mr_key_err: got %0b exp 0", key_err); end
    @(negedge clock);
    in_valid = 1'b0; out_ready = 1'b1; rst = 1'b1;
    @(negedge clock);
    send(8'h41, g, v);
    checks++; if (g !== 8'h41 || v !== 1'b1) begin errors++; $display("FAIL mr_after: dout=%h valid=%0b exp 41/1", g, v); end
  endtask

  initial begin
    rst = 1'b0; key_wr = 1'b0; key_addr = '0; key_data = '0; key_len = '0;
    mode = 2'b00; restart = 1'b0; in_valid = 1'b0; din = '0; out_ready = 1'b1;
    @(negedge clock); @(negedge clock);
    test_reset();
    rst = 1'b1;
    @(negedge clock);
    test_single();
    test_multi();
    test_nonletter();
    test_latch();
    test_backpressure();
    test_restart_coincide();
    test_key_err();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
